// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the symmetric FIR input stage.
// Build option: FIR_TAP_SEQ_FLUSH_EN adds a synchronous flush port.
package fir_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } seq_state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_TAPS = 16;

    function automatic int half_taps(input int n);
        return (n + 1) / 2;
    endfunction

    function automatic int idx_width(input int n);
        int h;
        h = half_taps(n);
        return (h < 2) ? 1 : $clog2(h);
    endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample-in / pair-out handshake bundle of the FIR tap sequencer.
// Build option: FIR_TAP_SEQ_FLUSH_EN (flush stays a plain port).
interface fir_tap_sequencer_if
    import fir_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_TAPS = DEF_NUM_TAPS
);
    localparam int IDX_W = idx_width(NUM_TAPS);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                    pair_valid;
    logic                    pair_ready;
    logic signed [DATA_W:0]  pair_sum;
    logic [IDX_W-1:0]        coef_idx;
    logic                    pair_last;

    modport master (
        output in_valid, in_data, pair_ready,
        input  in_ready, pair_valid, pair_sum, coef_idx, pair_last
    );

    modport slave (
        input  in_valid, in_data, pair_ready,
        output in_ready, pair_valid, pair_sum, coef_idx, pair_last
    );

endinterface

// File: rtl/fir_delay_line.sv
// Signed sample shift register, tap 0 newest, with shift enable and clear.
// Build option: FIR_TAP_SEQ_FLUSH_EN drives clr_i from the top.
module fir_delay_line #(
    parameter int W = 16,
    parameter int N = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                shift_i,
    input  logic signed [W-1:0] din_i,
    output logic signed [W-1:0] taps_o [N]
);
    logic signed [W-1:0] taps_q [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) taps_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < N; i++) taps_q[i] <= '0;
        end else if (shift_i) begin
            taps_q[0] <= din_i;
            for (int i = 1; i < N; i++) taps_q[i] <= taps_q[i-1];
        end
    end

    assign taps_o = taps_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Accepts samples and streams pre-added symmetric tap pairs to the MAC.
// Build option: FIR_TAP_SEQ_FLUSH_EN adds the flush input.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_TAPS = DEF_NUM_TAPS
) (
    input  logic clk,
    input  logic rst,
`ifdef FIR_TAP_SEQ_FLUSH_EN
    input  logic flush,
`endif
    fir_tap_sequencer_if.slave bus
);
    localparam int H     = half_taps(NUM_TAPS);
    localparam int IDX_W = idx_width(NUM_TAPS);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(H - 1);
    localparam bit ODD = (NUM_TAPS % 2) == 1;

    typedef logic signed [DATA_W-1:0] smp_t;
    typedef logic signed [DATA_W:0]   sum_t;

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    sum_t             sum_q, sum_d;
    logic             last_q, last_d;
    logic             flush_w;
    logic             accept;
    smp_t             taps    [NUM_TAPS];
    smp_t             shifted [NUM_TAPS];

`ifdef FIR_TAP_SEQ_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Centre tap of an odd filter has no partner and is passed through once.
    function automatic sum_t pair_at(input smp_t t [NUM_TAPS],
                                     input logic [IDX_W-1:0] k);
        sum_t s;
        s = '0;
        for (int i = 0; i < H; i++) begin
            if (IDX_W'(i) == k) begin
                if (ODD && i == H - 1)
                    s = sum_t'(t[i]);
                else
                    s = sum_t'(t[i]) + sum_t'(t[NUM_TAPS-1-i]);
            end
        end
        return s;
    endfunction

    assign accept = (state_q == IDLE) && bus.in_valid && !flush_w;

    fir_delay_line #(
        .W (DATA_W),
        .N (NUM_TAPS)
    ) u_dl (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush_w),
        .shift_i (accept),
        .din_i   (bus.in_data),
        .taps_o  (taps)
    );

    // View of the delay line after an accept, so beat 0 can be registered.
    always_comb begin
        shifted[0] = bus.in_data;
        for (int i = 1; i < NUM_TAPS; i++) shifted[i] = taps[i-1];
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sum_d   = sum_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    k_d     = '0;
                    sum_d   = pair_at(shifted, '0);
                    last_d  = (H == 1);
                end
            end
            RUN: begin
                if (bus.pair_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        k_d     = '0;
                        sum_d   = '0;
                        last_d  = 1'b0;
                    end else begin
                        k_d    = k_q + 1'b1;
                        sum_d  = pair_at(taps, k_d);
                        last_d = (k_d == K_LAST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_w) begin
            state_d = IDLE;
            k_d     = '0;
            sum_d   = '0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            sum_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE) && !rst;
    assign bus.pair_valid = (state_q == RUN);
    assign bus.pair_sum   = sum_q;
    assign bus.coef_idx   = k_q;
    assign bus.pair_last  = last_q;

endmodule
